muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide functional unit, directly downstream of a reservation station.

---
 rtl/muldiv_unit_pkg.sv | 25 ++
 rtl/muldiv_core.sv | 87 ++++++++
 rtl/muldiv_unit.sv | 109 ++++++++++
 tb/tb_muldiv_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package muldiv_unit_pkg;

    localparam int XLEN     = 32;
    localparam int ROB_IX_W = 3;
    localparam int OP_W     = 4;
    localparam int CNT_W    = $clog2(XLEN) + 1;

    typedef enum logic [OP_W-1:0] {
        FUNC_MUL    = 4'd0,
        FUNC_MULH   = 4'd1,
        FUNC_MULHSU = 4'd2,
        FUNC_MULHU  = 4'd3,
        FUNC_DIV    = 4'd4,
        FUNC_DIVU   = 4'd5,
        FUNC_REM    = 4'd6,
        FUNC_REMU   = 4'd7
    } muldiv_func_e;

    typedef struct packed {
        logic [ROB_IX_W-1:0] rob_ix;
        logic [XLEN-1:0]     value;
    } cdb_result_t;

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: shift-add multiply / restoring divide on operand magnitudes,
// with sign correction folded into the final step.
module muldiv_core
    import muldiv_unit_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            start,
    input  logic            step,
    input  logic            op_is_div,
    input  logic            finish,
    input  muldiv_func_e    func,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0]   hi, lo, mcand;
    logic              is_div, sel_alt, neg_main, neg_rem;

    logic              a_signed, b_signed, sa_neg, sb_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   hi_nxt, lo_nxt, quo_fix, rem_fix;
    logic [2*XLEN-1:0] prod, prod_fix;

    always_comb begin
        a_signed = func inside {FUNC_MULH, FUNC_MULHSU, FUNC_DIV, FUNC_REM};
        b_signed = func inside {FUNC_MULH, FUNC_DIV, FUNC_REM};
        sa_neg   = a_signed & a[XLEN-1];
        sb_neg   = b_signed & b[XLEN-1];
        mag_a    = sa_neg ? -a : a;
        mag_b    = sb_neg ? -b : b;
    end

    // Remainder is always below the divisor, so bit XLEN of the difference is a clean borrow.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand};
        if (is_div) begin
            hi_nxt = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            hi_nxt = mul_sum[XLEN:1];
            lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
        end
        prod     = {hi_nxt, lo_nxt};
        prod_fix = neg_main ? -prod : prod;
        quo_fix  = neg_main ? -lo_nxt : lo_nxt;
        rem_fix  = neg_rem ? -hi_nxt : hi_nxt;
        if (is_div) begin
            result = sel_alt ? rem_fix : quo_fix;
        end else begin
            result = sel_alt ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hi       <= '0;
            lo       <= '0;
            mcand    <= '0;
            is_div   <= 1'b0;
            sel_alt  <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (start) begin
            hi       <= '0;
            lo       <= op_is_div ? mag_a : mag_b;
            mcand    <= op_is_div ? mag_b : mag_a;
            is_div   <= op_is_div;
            sel_alt  <= op_is_div ? (func inside {FUNC_REM, FUNC_REMU}) : (func != FUNC_MUL);
            neg_main <= sa_neg ^ sb_neg;
            neg_rem  <= sa_neg;
        end else if (step) begin
            if (finish) begin
                hi <= '0;
                lo <= result;
            end else begin
                hi <= hi_nxt;
                lo <= lo_nxt;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide functional unit: dispatch FSM, fast-path results and CDB handshake.
//  state  | meaning
//  IDLE   | waiting for a dispatched op
//  BUSY   | one datapath iteration per cycle
//  DONE   | result held, requesting the CDB until granted
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                valid_in,
    input  logic [XLEN-1:0]     rval1_in,
    input  logic [XLEN-1:0]     rval2_in,
    input  logic [OP_W-1:0]     opcode_in,
    input  logic [ROB_IX_W-1:0] rob_ix_in,
    output logic                fu_busy_out,
    output logic                cdb_req_out,
    input  logic                cdb_grant_in,
    output logic [ROB_IX_W-1:0] cdb_rob_ix_out,
    output logic [XLEN-1:0]     cdb_value_out
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e          state;
    logic [CNT_W-1:0] cnt;
    cdb_result_t     held;

    logic            op_illegal, op_is_div, b_zero, div_ovf, fast_hit, accept, last_iter;
    logic [XLEN-1:0] fast_value, core_result;

    always_comb begin
        op_illegal = opcode_in[OP_W-1];
        op_is_div  = opcode_in[2] & ~op_illegal;
        b_zero     = (rval2_in == '0);
        div_ovf    = (opcode_in == FUNC_DIV || opcode_in == FUNC_REM)
                     && (rval1_in == {1'b1, {(XLEN-1){1'b0}}}) && (rval2_in == '1);
        fast_hit   = op_illegal || (op_is_div && b_zero) || div_ovf;
        fast_value = '0;
        if (!op_illegal && op_is_div && b_zero) begin
            fast_value = opcode_in[1] ? rval1_in : '1;
        end else if (div_ovf && !opcode_in[1]) begin
            fast_value = rval1_in;
        end
        accept    = (state == S_IDLE) && valid_in;
        last_iter = (state == S_BUSY) && (cnt == CNT_W'(XLEN - 1));
    end

    muldiv_core u_core (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .start     (accept && !fast_hit),
        .step      (state == S_BUSY),
        .op_is_div (op_is_div),
        .finish    (last_iter),
        .func      (muldiv_func_e'(opcode_in)),
        .a         (rval1_in),
        .b         (rval2_in),
        .result    (core_result)
    );

    // Request rises one edge after entering DONE, so fast-path and iterative results share timing.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= S_IDLE;
            cnt         <= '0;
            held        <= '0;
            fu_busy_out <= 1'b0;
            cdb_req_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_in) begin
                        held.rob_ix <= rob_ix_in;
                        cnt         <= '0;
                        fu_busy_out <= 1'b1;
                        if (fast_hit) begin
                            held.value <= fast_value;
                            state      <= S_DONE;
                        end else begin
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        held.value <= core_result;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!cdb_req_out) begin
                        cdb_req_out <= 1'b1;
                    end else if (cdb_grant_in) begin
                        cdb_req_out <= 1'b0;
                        fu_busy_out <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cdb_rob_ix_out = held.rob_ix;
    assign cdb_value_out  = held.value;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus hand-written stall and reset sequences.
module tb_muldiv_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        valid_in;
    logic [31:0] rval1_in, rval2_in;
    logic [3:0]  opcode_in;
    logic [2:0]  rob_ix_in;
    logic        fu_busy_out, cdb_req_out, cdb_grant_in;
    logic [2:0]  cdb_rob_ix_out;
    logic [31:0] cdb_value_out;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .valid_in       (valid_in),
        .rval1_in       (rval1_in),
        .rval2_in       (rval2_in),
        .opcode_in      (opcode_in),
        .rob_ix_in      (rob_ix_in),
        .fu_busy_out    (fu_busy_out),
        .cdb_req_out    (cdb_req_out),
        .cdb_grant_in   (cdb_grant_in),
        .cdb_rob_ix_out (cdb_rob_ix_out),
        .cdb_value_out  (cdb_value_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want summary");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Dispatch one op, scramble the inputs afterwards, wait for the request, grant at once.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] tag, output logic [31:0] val, output logic [2:0] t,
                          output int lat, output logic busy_e0, output logic busy_after);
        valid_in  = 1'b1;
        opcode_in = op;
        rval1_in  = a;
        rval2_in  = b;
        rob_ix_in = tag;
        tick();
        valid_in  = 1'b0;
        opcode_in = op ^ 4'h1;
        rval1_in  = ~a;
        rval2_in  = ~b;
        rob_ix_in = ~tag;
        busy_e0   = fu_busy_out;
        lat = 0;
        while (!cdb_req_out && lat < 100) begin
            tick();
            lat++;
        end
        val = cdb_value_out;
        t   = cdb_rob_ix_out;
        cdb_grant_in = 1'b1;
        tick();
        cdb_grant_in = 1'b0;
        busy_after = fu_busy_out | cdb_req_out;
        tick();
    endtask

    initial begin
        logic [31:0] val;
        logic [2:0]  t;
        int          lat;
        logic        b0, ba, seen_req;

        vecs.push_back('{4'd0, 32'd7,        32'hFFFFFFFD, 3'd5, 32'hFFFFFFEB, 33});
        vecs.push_back('{4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd1, 32'hFFFFFFFE, 33});
        vecs.push_back('{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2, 32'h00000000, 33});
        vecs.push_back('{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd3, 32'hFFFFFFFF, 33});
        vecs.push_back('{4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd4, 32'h00000001, 33});
        vecs.push_back('{4'd1, 32'hFFFFFFFE, 32'd3,        3'd6, 32'hFFFFFFFF, 33});
        vecs.push_back('{4'd4, 32'hFFFFFFF9, 32'd2,        3'd7, 32'hFFFFFFFD, 33});
        vecs.push_back('{4'd6, 32'hFFFFFFF9, 32'd2,        3'd0, 32'hFFFFFFFF, 33});
        vecs.push_back('{4'd5, 32'd7,        32'd2,        3'd1, 32'd3,        33});
        vecs.push_back('{4'd7, 32'd7,        32'd2,        3'd2, 32'd1,        33});
        vecs.push_back('{4'd4, 32'd100,      32'hFFFFFFF9, 3'd3, 32'hFFFFFFF2, 33});
        vecs.push_back('{4'd6, 32'd100,      32'hFFFFFFF9, 3'd4, 32'd2,        33});
        vecs.push_back('{4'd4, 32'h80000000, 32'd1,        3'd5, 32'h80000000, 33});
        vecs.push_back('{4'd4, 32'd5,        32'd0,        3'd6, 32'hFFFFFFFF, 1});
        vecs.push_back('{4'd6, 32'd5,        32'd0,        3'd7, 32'd5,        1});
        vecs.push_back('{4'd5, 32'd5,        32'd0,        3'd0, 32'hFFFFFFFF, 1});
        vecs.push_back('{4'd7, 32'd5,        32'd0,        3'd1, 32'd5,        1});
        vecs.push_back('{4'd4, 32'h80000000, 32'hFFFFFFFF, 3'd2, 32'h80000000, 1});
        vecs.push_back('{4'd6, 32'h80000000, 32'hFFFFFFFF, 3'd3, 32'd0,        1});
        vecs.push_back('{4'd12, 32'd9,       32'd4,        3'd4, 32'd0,        1});

        rst_in = 1'b1; valid_in = 1'b0; cdb_grant_in = 1'b0;
        rval1_in = '0; rval2_in = '0; opcode_in = '0; rob_ix_in = '0;
        repeat (3) tick();
        check("reset busy",  32'(fu_busy_out),    32'd0);
        check("reset req",   32'(cdb_req_out),    32'd0);
        check("reset tag",   32'(cdb_rob_ix_out), 32'd0);
        check("reset value", cdb_value_out,       32'd0);
        rst_in = 1'b0;
        tick();

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, val, t, lat, b0, ba);
            check($sformatf("v%0d value", i),      val,         vecs[i].exp);
            check($sformatf("v%0d tag", i),        32'(t),      32'(vecs[i].tag));
            check($sformatf("v%0d latency", i),    32'(lat),    32'(vecs[i].lat));
            check($sformatf("v%0d busy e0", i),    32'(b0),     32'd1);
            check($sformatf("v%0d idle grant", i), 32'(ba),     32'd0);
        end

        // Withheld grant, stray valid and stray grant while busy.
        valid_in = 1'b1; opcode_in = 4'd0; rval1_in = 32'd3; rval2_in = 32'd4; rob_ix_in = 3'd2;
        tick();
        valid_in = 1'b0;
        lat = 0;
        while (!cdb_req_out && lat < 100) begin
            cdb_grant_in = (lat == 10);
            tick();
            lat++;
        end
        cdb_grant_in = 1'b0;
        check("stall latency", 32'(lat), 32'd33);
        for (int k = 0; k < 10; k++) begin
            if (k == 5) begin
                valid_in = 1'b1; opcode_in = 4'd5; rval1_in = 32'd50; rval2_in = 32'd5; rob_ix_in = 3'd7;
            end
            tick();
            valid_in = 1'b0;
            check($sformatf("stall req c%0d", k),   32'(cdb_req_out),    32'd1);
            check($sformatf("stall value c%0d", k), cdb_value_out,       32'd12);
            check($sformatf("stall tag c%0d", k),   32'(cdb_rob_ix_out), 32'd2);
            check($sformatf("stall busy c%0d", k),  32'(fu_busy_out),    32'd1);
        end
        cdb_grant_in = 1'b1;
        tick();
        cdb_grant_in = 1'b0;
        check("stall busy after grant", 32'(fu_busy_out),    32'd0);
        check("stall req after grant",  32'(cdb_req_out),    32'd0);
        check("stall value kept",       cdb_value_out,       32'd12);
        check("stall tag kept",         32'(cdb_rob_ix_out), 32'd2);
        seen_req = 1'b0;
        repeat (40) begin
            tick();
            seen_req = seen_req | cdb_req_out | fu_busy_out;
        end
        check("stray valid ignored", 32'(seen_req), 32'd0);

        // Reset in the middle of an iterative op.
        valid_in = 1'b1; opcode_in = 4'd0; rval1_in = 32'd11; rval2_in = 32'd13; rob_ix_in = 3'd6;
        tick();
        valid_in = 1'b0;
        repeat (10) tick();
        check("mid busy", 32'(fu_busy_out), 32'd1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("mid reset busy",  32'(fu_busy_out),    32'd0);
        check("mid reset req",   32'(cdb_req_out),    32'd0);
        check("mid reset tag",   32'(cdb_rob_ix_out), 32'd0);
        check("mid reset value", cdb_value_out,       32'd0);
        tick();
        run_op(4'd5, 32'd100, 32'd7, 3'd3, val, t, lat, b0, ba);
        check("post reset value",   val,      32'd14);
        check("post reset tag",     32'(t),   32'd3);
        check("post reset latency", 32'(lat), 32'd33);
        check("post reset idle",    32'(ba),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
